// File: rtl/hour_set_ctrl_if.sv
// Edit-side bus of the hour setter: user pulses and running hour in,
// edit display and committed hour strobe out.
interface hour_set_ctrl_if;
  logic       hour_format;
  logic [5:0] hours_current;
  logic       set_req;
  logic       inc;
  logic       dec;
  logic       ampm_tgl;
  logic       confirm;
  logic       editing;
  logic [3:0] edit_h_digit_1;
  logic [3:0] edit_h_digit_0;
  logic       edit_pm;
  logic       hours_load;
  logic [5:0] hours_out;

  modport master (
    output hour_format, hours_current, set_req, inc, dec, ampm_tgl, confirm,
    input  editing, edit_h_digit_1, edit_h_digit_0, edit_pm, hours_load, hours_out
  );

  modport slave (
    input  hour_format, hours_current, set_req, inc, dec, ampm_tgl, confirm,
    output editing, edit_h_digit_1, edit_h_digit_0, edit_pm, hours_load, hours_out
  );
endinterface

// File: rtl/hour_set_ctrl.sv
// Hour-setting front end: captures the running hour, edits it in 12h or 24h
// form, and issues a one-cycle load of the 24h result on confirm.
module hour_set_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic           clk,
  input logic           reset,
  hour_set_ctrl_if.slave bus
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  state_t        state, state_nxt;
  logic [4:0]    edit_hr, edit_hr_nxt;
  logic          pm, pm_nxt;
  logic          fmt, fmt_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load_q, load_nxt;
  logic [5:0]    out_q, out_nxt;
  logic [3:0]    d1_q, d1_nxt, d0_q, d0_nxt;
  logic          editing_q;

  logic [5:0] hc;
  logic [5:0] hc_m12;
  logic [4:0] cap12;
  logic [5:0] conv12;
  logic [4:0] rem;

  // Out-of-range running hours are treated as midnight.
  assign hc     = (bus.hours_current > 6'd23) ? 6'd0 : bus.hours_current;
  assign hc_m12 = hc - 6'd12;

  always_comb begin
    cap12 = hc[4:0];
    if (hc == 6'd0 || hc == 6'd12) cap12 = 5'd12;
    else if (hc > 6'd12)           cap12 = hc_m12[4:0];
  end

  // 12 AM is hour 0 and 12 PM is hour 12; other hours just add the PM offset.
  always_comb begin
    conv12 = {1'b0, edit_hr} + (pm ? 6'd12 : 6'd0);
    if (edit_hr == 5'd12) conv12 = pm ? 6'd12 : 6'd0;
  end

  always_comb begin
    state_nxt   = state;
    edit_hr_nxt = edit_hr;
    pm_nxt      = pm;
    fmt_nxt     = fmt;
    cnt_nxt     = cnt;
    load_nxt    = 1'b0;
    out_nxt     = out_q;
    d1_nxt      = 4'd0;
    d0_nxt      = 4'd0;
    rem         = 5'd0;

    case (state)
      IDLE: begin
        if (bus.set_req) begin
          state_nxt   = EDIT;
          fmt_nxt     = bus.hour_format;
          cnt_nxt     = '0;
          pm_nxt      = (hc >= 6'd12);
          edit_hr_nxt = bus.hour_format ? cap12 : hc[4:0];
        end
      end
      EDIT: begin
        if (bus.hour_format != fmt) begin
          state_nxt = IDLE;
        end else if (bus.confirm) begin
          state_nxt = COMMIT;
          load_nxt  = 1'b1;
          out_nxt   = fmt ? conv12 : {1'b0, edit_hr};
          cnt_nxt   = '0;
        end else if (bus.inc || bus.dec) begin
          cnt_nxt = '0;
          if (bus.inc && !bus.dec) begin
            if (fmt) edit_hr_nxt = (edit_hr == 5'd12) ? 5'd1 : edit_hr + 5'd1;
            else     edit_hr_nxt = (edit_hr == 5'd23) ? 5'd0 : edit_hr + 5'd1;
          end else if (bus.dec && !bus.inc) begin
            if (fmt) edit_hr_nxt = (edit_hr == 5'd1) ? 5'd12 : edit_hr - 5'd1;
            else     edit_hr_nxt = (edit_hr == 5'd0) ? 5'd23 : edit_hr - 5'd1;
          end
          if (!fmt) pm_nxt = (edit_hr_nxt >= 5'd12);
        end else if (bus.ampm_tgl && fmt) begin
          pm_nxt  = !pm;
          cnt_nxt = '0;
        end else if (cnt == TMAX) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (edit_hr_nxt >= 5'd20) begin
      d1_nxt = 4'd2;
      rem    = edit_hr_nxt - 5'd20;
    end else if (edit_hr_nxt >= 5'd10) begin
      d1_nxt = 4'd1;
      rem    = edit_hr_nxt - 5'd10;
    end else begin
      rem    = edit_hr_nxt;
    end
    d0_nxt = rem[3:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      edit_hr   <= 5'd0;
      pm        <= 1'b0;
      fmt       <= 1'b0;
      cnt       <= '0;
      load_q    <= 1'b0;
      out_q     <= 6'd0;
      d1_q      <= 4'd0;
      d0_q      <= 4'd0;
      editing_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      edit_hr   <= edit_hr_nxt;
      pm        <= pm_nxt;
      fmt       <= fmt_nxt;
      cnt       <= cnt_nxt;
      load_q    <= load_nxt;
      out_q     <= out_nxt;
      d1_q      <= d1_nxt;
      d0_q      <= d0_nxt;
      editing_q <= (state_nxt == EDIT);
    end
  end

  assign bus.editing        = editing_q;
  assign bus.edit_h_digit_1 = d1_q;
  assign bus.edit_h_digit_0 = d0_q;
  assign bus.edit_pm        = pm;
  assign bus.hours_load     = load_q;
  assign bus.hours_out      = out_q;
endmodule

// File: tb/tb_hour_set_ctrl.sv
// Scoreboard bench: a reference model tracks the edit value as an absolute
// 24h hour; a monitor compares every cycle and every load strobe.
module tb_hour_set_ctrl;
  localparam int T = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hour_set_ctrl_if bus();
  hour_set_ctrl #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       editing;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       pm;
    logic       load;
    logic [5:0] out;
  } snap_t;

  snap_t      exp_q[$];
  logic [5:0] load_q[$];
  int checks = 0;
  int errors = 0;

  // Model state: mode 0=idle 1=edit 2=commit; m_h is the edit value as a 24h hour.
  int   m_mode, m_h, m_cnt, m_out;
  logic m_fmt, m_load;

  task automatic model_reset();
    m_mode = 0; m_h = 0; m_cnt = 0; m_out = 0; m_fmt = 1'b0; m_load = 1'b0;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    int disp;
    disp = m_fmt ? ((m_h % 12 == 0) ? 12 : m_h % 12) : m_h;
    s.editing = (m_mode == 1);
    s.d1      = 4'(disp / 10);
    s.d0      = 4'(disp % 10);
    s.pm      = (m_h >= 12);
    s.load    = m_load;
    s.out     = 6'(m_out);
    return s;
  endfunction

  task automatic model_step();
    int hc;
    m_load = 1'b0;
    case (m_mode)
      0: if (bus.set_req) begin
        hc     = int'(bus.hours_current);
        m_mode = 1;
        m_fmt  = bus.hour_format;
        m_h    = (hc > 23) ? 0 : hc;
        m_cnt  = 0;
      end
      1: begin
        if (bus.hour_format != m_fmt) m_mode = 0;
        else if (bus.confirm) begin
          m_mode = 2; m_load = 1'b1; m_out = m_h;
          load_q.push_back(6'(m_h));
        end else if (bus.inc || bus.dec) begin
          m_cnt = 0;
          if (bus.inc && !bus.dec)
            m_h = m_fmt ? (m_h / 12) * 12 + (m_h % 12 + 1) % 12 : (m_h + 1) % 24;
          else if (bus.dec && !bus.inc)
            m_h = m_fmt ? (m_h / 12) * 12 + (m_h % 12 + 11) % 12 : (m_h + 23) % 24;
        end else if (bus.ampm_tgl && m_fmt) begin
          m_h = (m_h + 12) % 24; m_cnt = 0;
        end else if (m_cnt == T - 1) m_mode = 0;
        else m_cnt++;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input bit s, input bit i, input bit d, input bit t, input bit c);
    bus.set_req = s; bus.inc = i; bus.dec = d; bus.ampm_tgl = t; bus.confirm = c;
    model_step();
    exp_q.push_back(model_snap());
    @(negedge clk);
  endtask

  task automatic chk_disp(input string name, input int d1, input int d0, input int pm);
    chk({name, "_d1"}, int'(bus.edit_h_digit_1), d1);
    chk({name, "_d0"}, int'(bus.edit_h_digit_0), d0);
    chk({name, "_pm"}, int'(bus.edit_pm), pm);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_editing"}, int'(bus.editing), 0);
    chk_disp(name, 0, 0, 0);
    chk({name, "_load"}, int'(bus.hours_load), 0);
    chk({name, "_out"}, int'(bus.hours_out), 0);
  endtask

  initial begin : monitor
    snap_t e;
    snap_t a;
    logic [5:0] le;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = {bus.editing, bus.edit_h_digit_1, bus.edit_h_digit_0, bus.edit_pm,
               bus.hours_load, bus.hours_out};
          checks++;
          if (a !== e) begin
            errors++;
            $display("FAIL snapshot: got %h expected %h (ed,d1,d0,pm,ld,out)", a, e);
          end
        end
        if (bus.hours_load) begin
          checks++;
          if (load_q.size() == 0) begin
            errors++;
            $display("FAIL load_unexpected: got hours_out %0d expected no load", bus.hours_out);
          end else begin
            le = load_q.pop_front();
            if (bus.hours_out !== le) begin
              errors++;
              $display("FAIL load_value: got %0d expected %0d", bus.hours_out, le);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : driver
    bus.hour_format = 1'b1; bus.hours_current = 6'd0;
    bus.set_req = 1'b0; bus.inc = 1'b0; bus.dec = 1'b0; bus.ampm_tgl = 1'b0; bus.confirm = 1'b0;
    model_reset();
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // 12h capture of midnight shows 12 AM and commits back to 0
    bus.hours_current = 6'd0;
    step(1, 0, 0, 0, 0);
    chk("t1_editing", int'(bus.editing), 1);
    chk_disp("t1", 1, 2, 0);
    step(0, 0, 0, 0, 1);
    chk("t1_load", int'(bus.hours_load), 1);
    chk("t1_out", int'(bus.hours_out), 0);
    step(0, 0, 0, 0, 0);
    chk("t1_load_once", int'(bus.hours_load), 0);

    // 11 AM + 1 wraps to 12 AM; toggling gives noon
    bus.hours_current = 6'd11;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk_disp("t2", 1, 2, 0);
    step(0, 0, 0, 0, 1);
    chk("t2_out", int'(bus.hours_out), 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("t2_out_pm", int'(bus.hours_out), 12);
    step(0, 0, 0, 0, 0);

    // 1 PM: dec to 12 PM, inc to 1 PM, then 3 PM
    bus.hours_current = 6'd13;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_disp("t3_dec", 1, 2, 1);
    step(0, 1, 0, 0, 0);
    chk_disp("t3_inc", 0, 1, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk_disp("t3_3pm", 0, 3, 1);
    step(0, 0, 0, 0, 1);
    chk("t3_out", int'(bus.hours_out), 15);
    step(0, 0, 0, 0, 0);

    // 24h wrap both ways, toggle ignored, inc+dec cancels
    bus.hour_format = 1'b0; bus.hours_current = 6'd23;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk_disp("t4_inc", 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_disp("t4_dec", 2, 3, 1);
    step(0, 0, 0, 1, 0);
    chk_disp("t4_tgl", 2, 3, 1);
    step(0, 1, 1, 0, 0);
    chk_disp("t4_both", 2, 3, 1);
    step(0, 0, 0, 0, 1);
    chk("t4_out", int'(bus.hours_out), 23);
    step(0, 0, 0, 0, 0);

    // Timeout after T idle edit cycles, then format-change abort
    bus.hour_format = 1'b1; bus.hours_current = 6'd5;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < T - 1; k++) step(0, 0, 0, 0, 0);
    chk("t5_still_editing", int'(bus.editing), 1);
    step(0, 0, 0, 0, 0);
    chk("t5_timeout", int'(bus.editing), 0);
    chk("t5_out_held", int'(bus.hours_out), 23);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    bus.hour_format = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("t5_abort", int'(bus.editing), 0);
    chk("t5_abort_load", int'(bus.hours_load), 0);
    step(0, 0, 0, 0, 0);
    bus.hour_format = 1'b1;

    // Reset arriving with confirm pending
    bus.hours_current = 6'd7;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    bus.confirm = 1'b1;
    #2 reset = 1'b1;
    #1 chk_zero("t6_async");
    @(negedge clk);
    bus.confirm = 1'b0;
    reset = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0);
    chk("t6_no_load", int'(bus.hours_load), 0);
    step(0, 0, 0, 0, 0);
    chk("t6_out", int'(bus.hours_out), 0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 39) == 0) bus.hour_format = ~bus.hour_format;
      bus.hours_current = 6'($urandom_range(0, 31));
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end
    for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0);
    #1;
    chk("pending_loads", load_q.size(), 0);
    chk("pending_snaps", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
